// File: rtl/gp_register_bank.sv
// gp_register_bank
//
// Sixteen-entry general-purpose register bank with instruction-register field
// select/encode logic. The registers feed the first sixteen inputs of the
// datapath bus multiplexer, and the one-hot out-enable feeds the bus source
// encoder. The bank also exports the sign-extended C constant from the IR.
//
// Ports:
//   clk          rising-edge clock
//   clr          synchronous active-high reset (registers and sel_err to 0)
//   bus_in       datapath bus value written on r_in
//   ir           instruction register (Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15])
//   gra/grb/grc  field selects, priority gra > grb > grc
//   r_in         write bus_in into the selected register
//   r_out        request out-enable strobe for the selected register
//   ba_out       base-address read request (out-enable, optional R0 zeroing)
//   r0_q..r15_q  register contents
//   reg_out_en   one-hot out-enable for the bus source encoder
//   sel_idx      decoded register index (0 when no field is selected)
//   c_sign_ext   ir[18:0] sign-extended to WIDTH bits
//   sel_err      sticky select-conflict flag, cleared only by clr
//
// Build option:
//   R0_BA_ZERO_EN  when defined, r0_q reads as zero while ba_out=1 (storage
//                  is unaffected); when undefined, r0_q always shows R0.

module gp_register_bank #(
   parameter int WIDTH = 32,
   parameter int NREGS = 16
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [WIDTH-1:0]  bus_in,
   input  logic [31:0]       ir,
   input  logic              gra,
   input  logic              grb,
   input  logic              grc,
   input  logic              r_in,
   input  logic              r_out,
   input  logic              ba_out,
   output logic [WIDTH-1:0]  r0_q,
   output logic [WIDTH-1:0]  r1_q,
   output logic [WIDTH-1:0]  r2_q,
   output logic [WIDTH-1:0]  r3_q,
   output logic [WIDTH-1:0]  r4_q,
   output logic [WIDTH-1:0]  r5_q,
   output logic [WIDTH-1:0]  r6_q,
   output logic [WIDTH-1:0]  r7_q,
   output logic [WIDTH-1:0]  r8_q,
   output logic [WIDTH-1:0]  r9_q,
   output logic [WIDTH-1:0]  r10_q,
   output logic [WIDTH-1:0]  r11_q,
   output logic [WIDTH-1:0]  r12_q,
   output logic [WIDTH-1:0]  r13_q,
   output logic [WIDTH-1:0]  r14_q,
   output logic [WIDTH-1:0]  r15_q,
   output logic [15:0]       reg_out_en,
   output logic [3:0]        sel_idx,
   output logic [WIDTH-1:0]  c_sign_ext,
   output logic              sel_err
);

   logic [WIDTH-1:0] regs [NREGS];
   logic             any_sel;
   logic             multi_sel;
   logic             set_err;
   logic             unused_ir;

   // Only the register fields and the C constant are consumed here.
   assign unused_ir = ^ir[31:27];

   // Field decode: highest-priority asserted field wins, index 0 when idle.
   always_comb begin
      sel_idx = 4'd0;
      if (gra)      sel_idx = ir[26:23];
      else if (grb) sel_idx = ir[22:19];
      else if (grc) sel_idx = ir[18:15];
   end

   assign any_sel   = gra | grb | grc;
   assign multi_sel = (gra & grb) | (gra & grc) | (grb & grc);

   // A read/write strobe with no field, or with several fields, is a control
   // unit error; the access still uses the highest-priority field.
   assign set_err = (r_in | r_out) & (~any_sel | multi_sel);

   // ba_out generates the same strobe as r_out; with no field selected there
   // is no register to enable, so the strobe stays silent.
   always_comb begin
      reg_out_en = 16'h0000;
      if ((r_out | ba_out) && any_sel)
         reg_out_en = 16'(1) << sel_idx;
   end

   assign c_sign_ext = {{(WIDTH-19){ir[18]}}, ir[18:0]};

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
         sel_err <= 1'b0;
      end else begin
         if (r_in && any_sel)
            regs[sel_idx] <= bus_in;
         if (set_err)
            sel_err <= 1'b1;
      end
   end

`ifdef R0_BA_ZERO_EN
   // Base-address-zero convention: R0 used as a base reads as zero.
   assign r0_q = ba_out ? '0 : regs[0];
`else
   assign r0_q = regs[0];
`endif
   assign r1_q  = regs[1];
   assign r2_q  = regs[2];
   assign r3_q  = regs[3];
   assign r4_q  = regs[4];
   assign r5_q  = regs[5];
   assign r6_q  = regs[6];
   assign r7_q  = regs[7];
   assign r8_q  = regs[8];
   assign r9_q  = regs[9];
   assign r10_q = regs[10];
   assign r11_q = regs[11];
   assign r12_q = regs[12];
   assign r13_q = regs[13];
   assign r14_q = regs[14];
   assign r15_q = regs[15];

endmodule
